// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in serial-out transmitter. A WIDTH-bit word is accepted on a
//   load/ready handshake and sent one bit per clk on Sout. frame qualifies
//   each valid data bit. done marks the last bit of a word. A new word may be
//   accepted in the last-bit cycle, so words can follow with no idle gap.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   load   word valid; a transfer happens when load & ready at an edge
//   Pin    parallel word, sampled only on a transfer edge
//   ready  block can take a word on this edge (IDLE or last-bit cycle)
//   Sout   serial data bit
//   frame  Sout carries a valid data bit
//   done   one-cycle pulse while the last bit of a word is on Sout
//   busy   in the SHIFT state
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] Pin,
  output logic             ready,
  output logic             Sout,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr_next;
  logic             last;

  // Shift toward the output end, zero-filling behind. After the final bit
  // leaves, the register is all zeros, so Sout is 0 in IDLE without gating.
  assign sr_next = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  assign last  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // Every output is a decode of flop state; nothing depends on the inputs.
  assign Sout  = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign frame = (state == SHIFT);
  assign busy  = (state == SHIFT);
  assign done  = last;
  assign ready = (state == IDLE) || last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sr    <= Pin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            cnt <= '0;
            if (load) begin
              // Back-to-back: the next word's first bit follows directly.
              sr <= Pin;
            end else begin
              sr    <= '0;
              state <= IDLE;
            end
          end else begin
            // Loads here are ignored: ready is low outside the last bit.
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sr    <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst, load, load_l;
  logic [3:0] Pin, pin_l;
  logic       ready, Sout, frame, done, busy;
  logic       ready_l, sout_l, frame_l, done_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .Pin(Pin),
    .ready(ready), .Sout(Sout), .frame(frame), .done(done), .busy(busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load(load_l), .Pin(pin_l),
    .ready(ready_l), .Sout(sout_l), .frame(frame_l), .done(done_l), .busy(busy_l)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; load_l = 1'b0; Pin = '0; pin_l = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({Sout, frame, done, busy, ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state: got Sout/frame/done/busy/ready=%b want 00001",
               {Sout, frame, done, busy, ready});
    end
    checks++;
    if ({sout_l, frame_l, done_l, busy_l, ready_l} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state_lsb: got %b want 00001",
               {sout_l, frame_l, done_l, busy_l, ready_l});
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    exp = 4'b1010;
    load = 1'b1; Pin = 4'b1010;
    tick();
    load = 1'b0; Pin = 4'b0101;  // changes after the transfer must not matter
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({Sout, frame, busy, done, ready} !== {exp[3-i], 2'b11, (i == 3), (i == 3)}) begin
        errors++;
        $display("FAIL basic_bit%0d: got Sout/frame/busy/done/ready=%b want %b", i,
                 {Sout, frame, busy, done, ready}, {exp[3-i], 2'b11, (i == 3), (i == 3)});
      end
      tick();
    end
    checks++;
    if ({Sout, frame, busy, done, ready} !== 5'b00001) begin
      errors++;
      $display("FAIL basic_idle: got %b want 00001", {Sout, frame, busy, done, ready});
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp;
    exp = 4'b1100;  // Pin=0011 sent LSB first
    load_l = 1'b1; pin_l = 4'b0011;
    tick();
    load_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sout_l, frame_l, done_l} !== {exp[3-i], 1'b1, (i == 3)}) begin
        errors++;
        $display("FAIL lsb_bit%0d: got Sout/frame/done=%b want %b", i,
                 {sout_l, frame_l, done_l}, {exp[3-i], 1'b1, (i == 3)});
      end
      tick();
    end
    checks++;
    if ({sout_l, frame_l, ready_l} !== 3'b001) begin
      errors++;
      $display("FAIL lsb_idle: got Sout/frame/ready=%b want 001", {sout_l, frame_l, ready_l});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp = 8'b1001_0110;
    load = 1'b1; Pin = 4'b1001;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({Sout, frame, done} !== {exp[7-i], 1'b1, (i == 3 || i == 7)}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got Sout/frame/done=%b want %b", i,
                 {Sout, frame, done}, {exp[7-i], 1'b1, (i == 3 || i == 7)});
      end
      if (i == 3) Pin = 4'b0110;   // presented in the first done cycle
      if (i == 4) load = 1'b0;     // second word already taken
      tick();
    end
    checks++;
    if ({Sout, frame, done, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_idle: got Sout/frame/done/ready=%b want 0001",
               {Sout, frame, done, ready});
    end
  endtask

  task automatic test_ignored_load();
    load = 1'b1; Pin = 4'b1111;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({Sout, frame} !== 2'b11) begin
        errors++;
        $display("FAIL ignored_bit%0d: got Sout/frame=%b want 11", i, {Sout, frame});
      end
      if (i == 1) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL ignored_ready: got %b want 0", ready);
        end
        load = 1'b1; Pin = 4'b0000;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    checks++;
    if ({Sout, frame, busy} !== 3'b000) begin
      errors++;
      $display("FAIL ignored_idle: got Sout/frame/busy=%b want 000", {Sout, frame, busy});
    end
    tick();
    checks++;
    if ({frame, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignored_no_second: got frame/done=%b want 00", {frame, done});
    end
  endtask

  task automatic test_midword_reset();
    logic [3:0] exp;
    load = 1'b1; Pin = 4'b1100;
    tick();
    load = 1'b0;
    tick();                        // second bit now on Sout
    checks++;
    if ({Sout, frame} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit1: got Sout/frame=%b want 11", {Sout, frame});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({Sout, frame, busy, ready, done} !== 5'b00010) begin
      errors++;
      $display("FAIL mid_reset: got Sout/frame/busy/ready/done=%b want 00010",
               {Sout, frame, busy, ready, done});
    end
    tick();
    checks++;
    if ({frame, done} !== 2'b00) begin
      errors++;
      $display("FAIL mid_no_done: got frame/done=%b want 00", {frame, done});
    end
    exp = 4'b0101;
    load = 1'b1; Pin = 4'b0101;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({Sout, frame, done} !== {exp[3-i], 1'b1, (i == 3)}) begin
        errors++;
        $display("FAIL mid_fresh_bit%0d: got Sout/frame/done=%b want %b", i,
                 {Sout, frame, done}, {exp[3-i], 1'b1, (i == 3)});
      end
      tick();
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; load = 1'b1; Pin = 4'b1111;
    tick();
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({Sout, frame, busy, ready} !== 4'b0001) begin
        errors++;
        $display("FAIL rst_prio_cyc%0d: got Sout/frame/busy/ready=%b want 0001", i,
                 {Sout, frame, busy, ready});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_ignored_load();
    test_midword_reset();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter. It is the sending end of the single-bit serial link that the serial-in parallel-out register receives.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clk cycle on Sout.
- Provides a frame qualifier and an end-of-word pulse, so a downstream serial-in parallel-out register can be fed directly.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- load  input  1  word-valid; a transfer occurs on any rising edge where load=1 and ready=1.
- Pin  input  WIDTH  parallel word; sampled only on a transfer edge.
- ready  output  1  block can accept a word on this edge.
- Sout  output  1  serial data bit, registered.
- frame  output  1  high while Sout carries a valid data bit.
- done  output  1  single-cycle pulse, high during the cycle the last bit of a word is on Sout.
- busy  output  1  high in the SHIFT state.

Behaviour:
- Reset values (rst=1 at an edge): state=IDLE, shift register=0, bit counter=0, Sout=0, frame=0, done=0, busy=0, ready=1 after reset.
- rst has priority over every other input.
- Reset mid-word aborts the word immediately: no remaining bits are sent and no done pulse is produced.
- States: IDLE, SHIFT.
- IDLE:
  - ready=1, Sout=0, frame=0.
  - On a transfer edge: capture Pin into the shift register, set counter=0, go to SHIFT.
- SHIFT:
  - frame=1, busy=1.
  - Sout = first-order bit of the shift register (MSB if MSB_FIRST=1, else LSB).
  - On each edge: shift the register one place toward the output end, zero-filling, and increment the counter.
- Latency: first bit appears on Sout in the cycle immediately after the transfer edge.
- Each word occupies exactly WIDTH consecutive cycles with frame=1.
- Last bit: when counter=WIDTH-1, done=1 and ready=1.
  - Transfer on that edge: reload from Pin, counter=0, stay in SHIFT. The next word's first bit follows with no gap and frame stays high.
  - No transfer on that edge: go to IDLE; Sout=0 and frame=0 next cycle.
- ready=0 in SHIFT except in the last-bit cycle. A load while ready=0 is ignored; Pin is not sampled and no state changes.
- Pin changes outside transfer edges have no effect on Sout.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1; it is cleared on reload or on return to IDLE.
- done never asserts in IDLE and never asserts twice for one word.
- rst and load on the same edge: reset wins and the word is dropped.

Test Plan:
- Basic send, WIDTH=4, MSB_FIRST=1: reset, then a single-cycle load with Pin=4'b1010.
  - Next 4 cycles: Sout=1,0,1,0 with frame=1 and busy=1.
  - done high only in the 4th cycle.
  - Then Sout=0, frame=0, ready=1.
- LSB-first, MSB_FIRST=0: load Pin=4'b0011 -> Sout=1,1,0,0 over 4 cycles.
- Back-to-back: hold load=1 with Pin=4'b1001, then change to 4'b0110 exactly at the first done cycle.
  - Sout=1,0,0,1,0,1,1,0 with frame high for 8 contiguous cycles.
  - done pulses in cycles 4 and 8.
- Ignored load: load Pin=4'b1111, then at bit 2 assert load with Pin=4'b0000 while ready=0 -> Sout stays 1,1,1,1, and the block returns to IDLE afterwards (no second word).
- Mid-word reset: load 4'b1100, assert rst at the 2nd bit.
  - Next cycle: Sout=0, frame=0, busy=0, ready=1, and no done pulse.
  - A fresh load of 4'b0101 then sends 0,1,0,1.
- Reset priority: rst=1 and load=1 on the same edge -> IDLE, no word sent, frame stays 0.
